// File: rtl/logic_unit_mxn_seq.sv
// Sequential bitwise logic unit: applies one of eight ops to SETS operand sets, one set per cycle.
// Optional build macro LU_ZERO_FLAGS_EN registers a per-set all-zero flag alongside each result.
module logic_unit_mxn_seq #(
  parameter int WIDTH = 4,
  parameter int SETS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [SETS*WIDTH-1:0] in1_packed,
  input  logic [SETS*WIDTH-1:0] in2_packed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SETS*WIDTH-1:0] out_packed,
  output logic                  busy,
  output logic [SETS-1:0]       zero_flags
);

  // state | meaning
  // IDLE  | waiting for a transaction, in_ready high
  // BUSY  | computing one operand set per cycle
  // DONE  | result held until out_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SETS - 1);

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [2:0]            op_q, op_d;
  logic [SETS*WIDTH-1:0] a_q, a_d;
  logic [SETS*WIDTH-1:0] b_q, b_d;
  logic [SETS*WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0]      set_res;
  logic                  accept;

  function automatic logic [WIDTH-1:0] set_op(input logic [2:0] o,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (o)
      3'b000:  r = a;
      3'b001:  r = ~a;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = ~(a & b);
      3'b101:  r = ~(a | b);
      3'b110:  r = a ^ b;
      default: r = ~(a ^ b);
    endcase
    return r;
  endfunction

  assign accept  = (state_q == IDLE) && in_valid;
  assign set_res = set_op(op_q, a_q[idx_q*WIDTH +: WIDTH], b_q[idx_q*WIDTH +: WIDTH]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op;
          a_d     = in1_packed;
          b_d     = in2_packed;
          idx_d   = '0;
          out_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        out_d[idx_q*WIDTH +: WIDTH] = set_res;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
    end
  end

`ifdef LU_ZERO_FLAGS_EN
  logic [SETS-1:0] zf_q, zf_d;

  always_comb begin
    zf_d = zf_q;
    if (accept) zf_d = '0;
    else if (state_q == BUSY) zf_d[idx_q] = ~|set_res;
  end

  always_ff @(posedge clk) begin
    if (rst) zf_q <= '0;
    else     zf_q <= zf_d;
  end

  assign zero_flags = zf_q;
`else
  assign zero_flags = '0;
`endif

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == BUSY);
  assign out_packed = out_q;

endmodule

// File: tb/tb_logic_unit_mxn_seq.sv
// Directed self-checking bench for logic_unit_mxn_seq at WIDTH=4, SETS=2.
module tb_logic_unit_mxn_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] in1_packed;
  logic [7:0] in2_packed;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_packed;
  logic       busy;
  logic [1:0] zero_flags;

  int checks = 0;
  int errors = 0;

  logic [7:0] sweep_exp [8] = '{8'hA5, 8'h5A, 8'h24, 8'hBD, 8'hDB, 8'h42, 8'h99, 8'h66};

  logic_unit_mxn_seq #(.WIDTH(4), .SETS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .in1_packed (in1_packed),
    .in2_packed (in2_packed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_packed (out_packed),
    .busy       (busy),
    .zero_flags (zero_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_nib(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    case (o)
      3'd0: return a;
      3'd1: return ~a;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic logic [1:0] ref_zf(input logic [7:0] r);
`ifdef LU_ZERO_FLAGS_EN
    return {r[7:4] == 4'h0, r[3:0] == 4'h0};
`else
    return 2'b00;
`endif
  endfunction

  // Starts and ends just after a falling edge; latency counted in rising edges after acceptance.
  task automatic do_txn(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic [1:0] zf);
    int lat;
    op = o; in1_packed = a; in2_packed = b; in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 2);
    res = out_packed;
    zf  = zero_flags;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_done", in_ready, 1);
  endtask

  initial begin
    logic [7:0] res, held, a, b, e;
    logic [1:0] zf;
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0;
    in1_packed = 8'h00; in2_packed = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_packed", out_packed, 8'h00);
    chk("rst_zero_flags", zero_flags, 2'b00);

    do_txn(3'b010, 8'hA5, 8'h3C, res, zf);
    chk("and_a5_3c", res, 8'h24);

    // New transaction clears the old result, then fills set 0 before set 1
    op = 3'b000; in1_packed = 8'hA5; in2_packed = 8'h3C; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("clear_at_accept", out_packed, 8'h00);
    chk("busy_first", busy, 1);
    @(negedge clk);
    chk("partial_set0", out_packed, 8'h05);
    @(negedge clk);
    chk("pass_done_valid", out_valid, 1);
    chk("pass_done_val", out_packed, 8'hA5);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    for (int o = 0; o < 8; o++) begin
      do_txn(3'(o), 8'hA5, 8'h3C, res, zf);
      chk($sformatf("sweep_op%0d", o), res, sweep_exp[o]);
    end

    do_txn(3'b010, 8'h0F, 8'hF0, res, zf);
    chk("and_zero_res", res, 8'h00);
    chk("and_zero_flags", zf, ref_zf(8'h00));

    // Consumer stalls in DONE while a producer keeps offering
    op = 3'b110; in1_packed = 8'hA5; in2_packed = 8'h3C; in_valid = 1'b1;
    @(negedge clk);
    repeat (2) @(negedge clk);
    chk("stall_valid0", out_valid, 1);
    held = out_packed;
    chk("stall_val", held, 8'h99);
    for (int i = 0; i < 5; i++) begin
      in1_packed = 8'h11 * i; in2_packed = 8'hFF;
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_hold", out_packed, held);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in1_packed = 8'hF0; in2_packed = 8'h0F; op = 3'b011;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_busy", busy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("second_accept", busy, 1);
    repeat (2) @(negedge clk);
    chk("second_val", out_packed, 8'hFF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the first BUSY cycle abandons the transaction
    op = 3'b011; in1_packed = 8'hA5; in2_packed = 8'h3C; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy_in_ready", in_ready, 1);
    chk("rst_busy_out", out_packed, 8'h00);
    chk("rst_busy_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_valid", seen, 0);

    // Reset wins over acceptance on the same edge
    in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_ready", in_ready, 1);

    for (int o = 0; o < 8; o++) begin
      for (int v = 0; v < 256; v++) begin
        a = {v[3:0], v[7:4]};
        b = {v[7:4], v[3:0]};
        e = {ref_nib(3'(o), a[7:4], b[7:4]), ref_nib(3'(o), a[3:0], b[3:0])};
        do_txn(3'(o), a, b, res, zf);
        chk($sformatf("exh_op%0d_v%0d", o, v), res, e);
        chk($sformatf("exh_zf_op%0d_v%0d", o, v), zf, ref_zf(e));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/logic_unit_mxn_seq.md
LOGIC_UNIT_MXN_SEQ -- requirements
Module: logic_unit_mxn_seq

Interface
REQ-001 Parameter WIDTH, default 4, bits per operand set.
REQ-002 Parameter SETS, default 2, number of operand sets per transaction; legal range 1..256.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  transaction offered.
REQ-006 in_ready  output  1  unit can accept a transaction.
REQ-007 op  input  3  operation select, sampled at acceptance.
REQ-008 in1_packed  input  SETS*WIDTH  operand A; set i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in2_packed  input  SETS*WIDTH  operand B; same packing as operand A.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_packed  output  SETS*WIDTH  result; same packing as the operands.
REQ-013 busy  output  1  high in state BUSY.
REQ-014 zero_flags  output  SETS  bit i is high when result set i is all zeros (see REQ-031).

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-016 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-017 In IDLE, in_valid&&in_ready SHALL:
- capture op, in1_packed and in2_packed into internal registers;
- clear set index idx to 0;
- go to BUSY.
REQ-018 Inputs SHALL be ignored outside IDLE; captured operands SHALL remain stable while BUSY and DONE.
REQ-019 In BUSY, each cycle SHALL compute set idx from captured operands, write it to out_packed[idx*WIDTH +: WIDTH], then increment idx.
REQ-020 When idx==SETS-1 in BUSY, the FSM SHALL go to DONE; out_valid SHALL rise exactly SETS cycles after the acceptance edge.
REQ-021 Op encoding, bitwise per set:
- 000 PASS A; 001 NOT A; 010 AND; 011 OR;
- 100 NAND; 101 NOR; 110 XOR; 111 XNOR.
REQ-022 In DONE, out_packed and zero_flags SHALL hold until out_ready is high; out_valid&&out_ready SHALL return the FSM to IDLE on that edge.
REQ-023 A new transaction SHALL be accepted no earlier than the cycle after the DONE->IDLE edge; throughput is one transaction per SETS+2 cycles.
REQ-024 Result bits not yet written in the current transaction SHALL be 0: out_packed clears at acceptance.
REQ-025 With SETS==1, BUSY SHALL last exactly one cycle.
REQ-026 The idx counter SHALL be ceil(log2(SETS)) bits wide, minimum 1, and SHALL never exceed SETS-1.

Reset
REQ-027 rst high at a rising edge SHALL force state IDLE and idx=0, and clear out_packed, zero_flags and the captured registers to 0.
REQ-028 Reset SHALL take priority over every other event, including acceptance and result handshake on the same edge.
REQ-029 A reset in BUSY or DONE SHALL abandon the transaction; no out_valid pulse follows.
REQ-030 Output values after reset: in_ready=1, out_valid=0, busy=0, out_packed=0, zero_flags=0.

Configuration
REQ-031 Macro LU_ZERO_FLAGS_EN:
- when defined, zero_flags[idx] SHALL be registered alongside each set result and held in DONE;
- when undefined, zero_flags SHALL be tied to 0, with the port still present and no flag logic synthesised.

Verification (WIDTH=4, SETS=2)
REQ-032 op=010, A=8'hA5, B=8'h3C, accepted at edge 0 -> out_valid high after edge 2, out_packed=8'h24.
REQ-033 Run the 8-op sweep with A=8'hA5, B=8'h3C -> out_packed equals A5, 5A, 24, BD, DB, 42, 99, 66 respectively.
REQ-034 op=010, A=8'h0F, B=8'hF0 -> out_packed=8'h00; zero_flags=2'b11 with LU_ZERO_FLAGS_EN defined, 2'b00 without.
REQ-035 out_ready held low for 5 cycles in DONE, in_valid held high -> out_valid and out_packed stable, in_ready=0, no second acceptance until 1 cycle after the handshake.
REQ-036 rst pulsed in the first BUSY cycle -> next cycle state IDLE, in_ready=1, out_packed=8'h00; no out_valid follows.
REQ-037 Exhaustive sweep of all 16x16 values on set 0 and set 1 with each op -> every result matches a bitwise reference model.
